// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer:
// FSM states, instruction classes, opcodes and immediate formats.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LD   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_BR   = 3'd3,
        CLS_HALT = 3'd4,
        CLS_ILL  = 3'd5
    } cls_e;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: static datapath controls plus the
// instruction class that steers the sequencer.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int HALT_ON_ZERO = 1
) (
    input  logic [31:0] ir,
    output logic [1:0]  imms,
    output logic        alusrc,
    output logic [2:0]  aluop,
    output logic        sub,
    output logic        mtr,
    output cls_e        cls
);

    logic [2:0] funct3;
    assign funct3 = ir[14:12];

    always_comb begin
        imms   = '0;
        alusrc = 1'b0;
        aluop  = '0;
        sub    = 1'b0;
        mtr    = 1'b1;
        cls    = CLS_ILL;
        case (ir[6:0])
            OP_R: begin
                aluop = funct3;
                sub   = ir[30];
                cls   = CLS_ALU;
            end
            OP_I: begin
                alusrc = 1'b1;
                imms   = IMM_I;
                aluop  = funct3;
                sub    = (funct3 == 3'b101) && ir[30];
                cls    = CLS_ALU;
            end
            OP_LD: begin
                alusrc = 1'b1;
                imms   = IMM_I;
                mtr    = 1'b0;
                cls    = CLS_LD;
            end
            OP_ST: begin
                alusrc = 1'b1;
                imms   = IMM_S;
                cls    = CLS_ST;
            end
            OP_BR: begin
                imms = IMM_B;
                sub  = 1'b1;
                cls  = CLS_BR;
            end
            default: ;
        endcase
        // Halt words override whatever the opcode field decoded to.
        if (((HALT_ON_ZERO != 0) && (ir == '0)) || (ir == EBREAK)) begin
            cls = CLS_HALT;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: latches the instruction, steps the FSM and
// emits one-cycle PC / memory / register-file enables for a clk-retimed datapath.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      I,
    input  logic             Z,
    input  logic             N,
    input  logic             Cout,
    output logic             pc_we,
    output logic             MRW,
    output logic             rf_we,
    output logic [1:0]       IMMs,
    output logic             ALUsrc,
    output logic [2:0]       ALUop,
    output logic             sub,
    output logic             PCsrc,
    output logic             MTR,
    output logic [31:0]      ir,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    cls_e             cls;
    logic             br_taken;
    logic             unused_cout;

    assign unused_cout = Cout;

    ctrl_decode #(.HALT_ON_ZERO(HALT_ON_ZERO)) u_decode (
        .ir     (ir_q),
        .imms   (IMMs),
        .alusrc (ALUsrc),
        .aluop  (ALUop),
        .sub    (sub),
        .mtr    (MTR),
        .cls    (cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (cls == CLS_HALT)     state_d = HALT;
                else if (cls == CLS_ILL) state_d = FETCH;
                else                     state_d = EXEC;
            end
            EXEC: begin
                if (cls == CLS_BR)                         state_d = FETCH;
                else if ((cls == CLS_LD) || (cls == CLS_ST)) state_d = MEM;
                else                                       state_d = WB;
            end
            MEM:     state_d = (cls == CLS_LD) ? WB : FETCH;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Branch resolves from the flags the datapath presents during EXEC.
    always_comb begin
        case (ir_q[14:12])
            3'b000:  br_taken = Z;
            3'b001:  br_taken = !Z;
            3'b100:  br_taken = N;
            3'b101:  br_taken = !N;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_we   = 1'b0;
        MRW     = 1'b0;
        rf_we   = 1'b0;
        PCsrc   = 1'b0;
        illegal = 1'b0;
        halted  = 1'b0;
        case (state_q)
            DECODE: begin
                if (cls == CLS_ILL) begin
                    illegal = 1'b1;
                    pc_we   = 1'b1;
                end
            end
            EXEC: begin
                if (cls == CLS_BR) begin
                    pc_we = 1'b1;
                    PCsrc = br_taken;
                end
            end
            MEM: begin
                if (cls == CLS_ST) begin
                    MRW   = 1'b1;
                    pc_we = 1'b1;
                end
            end
            WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ir_d      = (state_q == FETCH) ? I : ir_q;
        retired_d = (pc_we && !illegal) ? retired_q + CNT_W'(1) : retired_q;
    end

    assign ir      = ir_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: each task steps one
// scenario cycle by cycle and compares against hand-computed values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] I;
    logic        Z, N, Cout;
    logic        pc_we, MRW, rf_we, ALUsrc, sub, PCsrc, MTR, illegal, halted;
    logic [1:0]  IMMs;
    logic [2:0]  ALUop, state;
    logic [31:0] ir;
    logic [7:0]  retired;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    // {pc_we, MRW, rf_we, PCsrc, illegal, halted}
    logic [5:0] strb;
    // {IMMs, ALUsrc, ALUop, sub, MTR}
    logic [7:0] ctrl;
    assign strb = {pc_we, MRW, rf_we, PCsrc, illegal, halted};
    assign ctrl = {IMMs, ALUsrc, ALUop, sub, MTR};

    localparam logic [31:0] ADD = 32'h0020_81B3;
    localparam logic [31:0] LW  = 32'h0080_2203;
    localparam logic [31:0] SW  = 32'h0040_2623;

    multicycle_ctrl #(.CNT_W(8), .HALT_ON_ZERO(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .I       (I),
        .Z       (Z),
        .N       (N),
        .Cout    (Cout),
        .pc_we   (pc_we),
        .MRW     (MRW),
        .rf_we   (rf_we),
        .IMMs    (IMMs),
        .ALUsrc  (ALUsrc),
        .ALUop   (ALUop),
        .sub     (sub),
        .PCsrc   (PCsrc),
        .MTR     (MTR),
        .ir      (ir),
        .state   (state),
        .illegal (illegal),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        chk_cnt++; if (state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", state); else pass_cnt++;
        chk_cnt++; if (ir !== 32'h0) $display("FAIL rst_ir got=%h exp=0", ir); else pass_cnt++;
        chk_cnt++; if (strb !== 6'b0) $display("FAIL rst_strb got=%b exp=000000", strb); else pass_cnt++;
        chk_cnt++; if (ctrl !== 8'b00_0_000_0_1) $display("FAIL rst_ctrl got=%b exp=00000001", ctrl); else pass_cnt++;
        I = ADD;
        reset = 1'b0;
        repeat (4) cyc();
        chk_cnt++; if (retired !== 8'd1) $display("FAIL rst_pre_ret got=%0d exp=1", retired); else pass_cnt++;
        cyc();
        cyc();
        chk_cnt++; if (state !== 3'd2) $display("FAIL rst_in_exec got=%0d exp=2", state); else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++; if ({state, strb, retired} !== 17'b0)
            $display("FAIL rst_async got state=%0d strb=%b ret=%0d exp 0/000000/0", state, strb, retired);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb, retired} !== 17'b0)
            $display("FAIL rst_held got state=%0d strb=%b ret=%0d exp 0/000000/0", state, strb, retired);
        else pass_cnt++;
        I = 32'h1234_5678;
        reset = 1'b0;
        cyc();
        chk_cnt++; if ({state, ir} !== {3'd1, 32'h1234_5678})
            $display("FAIL rst_fetch got state=%0d ir=%h exp 1/12345678", state, ir);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_add();
        I = ADD;
        chk_cnt++; if (strb !== 6'b0) $display("FAIL add_fetch got=%b exp=000000", strb); else pass_cnt++;
        cyc();
        chk_cnt++; if ({strb, ctrl} !== {6'b0, 8'b00_0_000_0_1})
            $display("FAIL add_decode got strb=%b ctrl=%b exp 000000/00000001", strb, ctrl);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd2, 6'b0})
            $display("FAIL add_exec got state=%0d strb=%b exp 2/000000", state, strb);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd4, 6'b101000})
            $display("FAIL add_wb got state=%0d strb=%b exp 4/101000", state, strb);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, retired} !== {3'd0, 8'd1})
            $display("FAIL add_ret got state=%0d ret=%0d exp 0/1", state, retired);
        else pass_cnt++;
    endtask

    task automatic test_load_store();
        I = LW;
        cyc();
        chk_cnt++; if ({strb, ctrl} !== {6'b0, 8'b00_1_000_0_0})
            $display("FAIL lw_decode got strb=%b ctrl=%b exp 000000/00100000", strb, ctrl);
        else pass_cnt++;
        cyc();
        chk_cnt++; if (strb !== 6'b0) $display("FAIL lw_exec got=%b exp=000000", strb); else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd3, 6'b0})
            $display("FAIL lw_mem got state=%0d strb=%b exp 3/000000", state, strb);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd4, 6'b101000})
            $display("FAIL lw_wb got state=%0d strb=%b exp 4/101000", state, strb);
        else pass_cnt++;
        I = SW;
        cyc();
        chk_cnt++; if ({state, retired} !== {3'd0, 8'd2})
            $display("FAIL lw_ret got state=%0d ret=%0d exp 0/2", state, retired);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({strb, ctrl[7:1]} !== {6'b0, 7'b01_1_000_0})
            $display("FAIL sw_decode got strb=%b ctrl=%b exp 000000/0110000", strb, ctrl[7:1]);
        else pass_cnt++;
        cyc();
        chk_cnt++; if (strb !== 6'b0) $display("FAIL sw_exec got=%b exp=000000", strb); else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd3, 6'b110000})
            $display("FAIL sw_mem got state=%0d strb=%b exp 3/110000", state, strb);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, retired} !== {3'd0, 8'd3})
            $display("FAIL sw_ret got state=%0d ret=%0d exp 0/3", state, retired);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        logic [31:0] ins [5] = '{32'h0000_0463, 32'h0000_0463, 32'h0000_1463, 32'h0000_4463, 32'h0000_5463};
        logic        zs  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        ns  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0]  exp [5] = '{6'b100100, 6'b100000, 6'b100100, 6'b100100, 6'b100000};
        for (int i = 0; i < 5; i++) begin
            I = ins[i];
            Z = zs[i];
            N = ns[i];
            cyc();
            chk_cnt++; if ({strb, ctrl[7:1]} !== {6'b0, 7'b10_0_000_1})
                $display("FAIL br%0d_decode got strb=%b ctrl=%b exp 000000/1000001", i, strb, ctrl[7:1]);
            else pass_cnt++;
            cyc();
            chk_cnt++; if ({state, strb} !== {3'd2, exp[i]})
                $display("FAIL br%0d_exec got state=%0d strb=%b exp 2/%b", i, state, strb, exp[i]);
            else pass_cnt++;
            cyc();
        end
        Z = 1'b0;
        N = 1'b0;
        chk_cnt++; if ({state, retired} !== {3'd0, 8'd8})
            $display("FAIL br_ret got state=%0d ret=%0d exp 0/8", state, retired);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        I = 32'h0000_007F;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd1, 6'b100010})
            $display("FAIL ill_decode got state=%0d strb=%b exp 1/100010", state, strb);
        else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb, retired} !== {3'd0, 6'b0, 8'd8})
            $display("FAIL ill_after got state=%0d strb=%b ret=%0d exp 0/000000/8", state, strb, retired);
        else pass_cnt++;
    endtask

    task automatic test_ebreak();
        I = 32'h0010_0073;
        cyc();
        chk_cnt++; if (strb !== 6'b0) $display("FAIL ebreak_decode got=%b exp=000000", strb); else pass_cnt++;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd5, 6'b000001})
            $display("FAIL ebreak_halt got state=%0d strb=%b exp 5/000001", state, strb);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_halt();
        I = 32'h0;
        cyc();
        chk_cnt++; if ({state, strb} !== {3'd1, 6'b0})
            $display("FAIL halt_decode got state=%0d strb=%b exp 1/000000", state, strb);
        else pass_cnt++;
        I = ADD;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_cnt++; if ({state, strb, retired} !== {3'd5, 6'b000001, 8'd0})
                $display("FAIL halt_hold%0d got state=%0d strb=%b ret=%0d exp 5/000001/0", i, state, strb, retired);
            else pass_cnt++;
        end
        do_reset();
    endtask

    task automatic test_wrap();
        I = ADD;
        repeat (255) repeat (4) cyc();
        chk_cnt++; if ({state, retired} !== {3'd0, 8'd255})
            $display("FAIL wrap_255 got state=%0d ret=%0d exp 0/255", state, retired);
        else pass_cnt++;
        repeat (4) cyc();
        chk_cnt++; if ({state, retired} !== {3'd0, 8'd0})
            $display("FAIL wrap_0 got state=%0d ret=%0d exp 0/0", state, retired);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        I     = 32'h0;
        Z     = 1'b0;
        N     = 1'b0;
        Cout  = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_load_store();
        test_branch();
        test_illegal();
        test_ebreak();
        test_halt();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
